// File: rtl/crypto_bus_arb.sv
// Two-requester round-robin arbiter onto a shared 4-slave crypto bus,
// with address decode, per-transaction timeout and error completion.
module crypto_bus_arb #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          TIMEOUT   = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   m0_addr,
   input  logic [31:0]   m0_wdata,
   input  logic          m0_we,
   input  logic          m0_valid,
   output logic [31:0]   m0_rdata,
   output logic          m0_ready,
   output logic          m0_err,
   input  logic [31:0]   m1_addr,
   input  logic [31:0]   m1_wdata,
   input  logic          m1_we,
   input  logic          m1_valid,
   output logic [31:0]   m1_rdata,
   output logic          m1_ready,
   output logic          m1_err,
   output logic [31:0]   s_addr,
   output logic [31:0]   s_wdata,
   output logic          s_we,
   output logic          s_valid,
   input  logic [127:0]  s_rdata,
   input  logic [3:0]    s_ready,
   output logic [1:0]    grant
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic        ptr;
   logic        pick;
   logic [31:0] pick_addr;
   logic [31:0] pick_wdata;
   logic        pick_we;
   logic [1:0]  slv;
   logic [31:0] slice;

   // ptr=1 means m1 has priority when both request
   always_comb begin
      pick       = m1_valid & (~m0_valid | ptr);
      pick_addr  = pick ? m1_addr  : m0_addr;
      pick_wdata = pick ? m1_wdata : m0_wdata;
      pick_we    = pick ? m1_we    : m0_we;
   end

   assign slv   = s_addr[13:12];
   assign slice = s_rdata[{slv, 5'b0} +: 32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         ptr      <= 1'b0;
         grant    <= '0;
         s_addr   <= '0;
         s_wdata  <= '0;
         s_we     <= 1'b0;
         s_valid  <= 1'b0;
         m0_rdata <= '0;
         m0_ready <= 1'b0;
         m0_err   <= 1'b0;
         m1_rdata <= '0;
         m1_ready <= 1'b0;
         m1_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (m0_valid | m1_valid) begin
                  s_addr  <= pick_addr;
                  s_wdata <= pick_wdata;
                  s_we    <= pick_we;
                  grant   <= pick ? 2'b10 : 2'b01;
                  if (pick_addr[31:14] == BASE_ADDR[31:14]) begin
                     s_valid <= 1'b1;
                     state   <= ISSUE;
                  end else begin
                     m0_ready <= ~pick;
                     m0_err   <= ~pick;
                     m1_ready <= pick;
                     m1_err   <= pick;
                     state    <= RESP;
                  end
               end
            end
            ISSUE: begin
               s_valid <= 1'b0;
               cnt     <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               if (s_ready[slv]) begin
                  m0_ready <= grant[0];
                  m1_ready <= grant[1];
                  m0_rdata <= (grant[0] & ~s_we) ? slice : '0;
                  m1_rdata <= (grant[1] & ~s_we) ? slice : '0;
                  state    <= RESP;
               end else if (cnt == LAST) begin
                  m0_ready <= grant[0];
                  m1_ready <= grant[1];
                  m0_err   <= grant[0];
                  m1_err   <= grant[1];
                  state    <= RESP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP: begin
               m0_ready <= 1'b0;
               m0_err   <= 1'b0;
               m0_rdata <= '0;
               m1_ready <= 1'b0;
               m1_err   <= 1'b0;
               m1_rdata <= '0;
               ptr      <= grant[0];
               grant    <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crypto_bus_arb.sv
// Bench for crypto_bus_arb: directed scenarios then randomized
// transactions against a transaction-level reference model.
module tb_crypto_bus_arb;

   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   m0_addr = '0, m0_wdata = '0;
   logic          m0_we = 1'b0, m0_valid = 1'b0;
   logic [31:0]   m0_rdata;
   logic          m0_ready, m0_err;
   logic [31:0]   m1_addr = '0, m1_wdata = '0;
   logic          m1_we = 1'b0, m1_valid = 1'b0;
   logic [31:0]   m1_rdata;
   logic          m1_ready, m1_err;
   logic [31:0]   s_addr, s_wdata;
   logic          s_we, s_valid;
   logic [127:0]  s_rdata = '0;
   logic [3:0]    s_ready = '0;
   logic [1:0]    grant;

   int checks = 0;
   int failures = 0;
   int last_g = 1;
   logic [31:0] base_v = 32'h4000_0000;

   crypto_bus_arb #(.BASE_ADDR(32'h4000_0000), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_valid(m0_valid), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
      .m0_err(m0_err),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_valid(m1_valid), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
      .m1_err(m1_err),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
      .s_valid(s_valid), .s_rdata(s_rdata), .s_ready(s_ready),
      .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      if ($urandom_range(0, 3) != 0) begin
         a = {base_v[31:14], 14'($urandom) & 14'h3FFC};
      end else begin
         a = $urandom;
         if (a[31:14] == base_v[31:14]) a[31] = ~a[31];
      end
      return a;
   endfunction

   // dly: slave ready this many cycles after s_valid; 0 = never
   task automatic txn(input bit v0, input bit v1,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input bit we0, input bit we1, input int dly,
                      input bit keep, input bit early, input bit stray,
                      input bit fuse, input logic [31:0] fdat);
      int w, r, k;
      bit inr, ok, wwe;
      logic [31:0] wa, wd, exp_rd;
      logic [1:0] g;
      w = (v0 && v1) ? ((last_g == 0) ? 1 : 0) : (v1 ? 1 : 0);
      wa = w ? a1 : a0;
      wd = w ? d1 : d0;
      wwe = w ? we1 : we0;
      g = w ? 2'b10 : 2'b01;
      inr = (wa[31:14] == base_v[31:14]);
      k = int'(wa[13:12]);
      ok = inr && dly >= 1 && dly <= TO;
      r = !inr ? 1 : (ok ? dly + 2 : TO + 2);
      exp_rd = '0;
      m0_addr = a0; m0_wdata = d0; m0_we = we0; m0_valid = v0;
      m1_addr = a1; m1_wdata = d1; m1_we = we1; m1_valid = v1;
      for (int n = 1; n <= r; n++) begin
         @(posedge clk); #1;
         if (early && n == 1) begin
            m0_valid = 1'b0;
            m1_valid = 1'b0;
         end
         s_rdata = {$urandom, $urandom, $urandom, $urandom};
         s_ready = stray ? (4'($urandom) | 4'b0001) : 4'b0000;
         if (inr) begin
            s_ready[k] = (stray && n == 1) || (ok && n == dly + 1);
            if (ok && n == dly + 1) begin
               if (fuse) s_rdata[32*k +: 32] = fdat;
               exp_rd = wwe ? 32'h0 : s_rdata[32*k +: 32];
            end
         end
         chk("grant", grant, g);
         chk("s_valid", s_valid, inr && n == 1);
         if (inr && n == 1) begin
            chk("s_addr", s_addr, wa);
            chk("s_wdata", s_wdata, wd);
            chk("s_we", s_we, wwe);
         end
         chk("win_ready", w ? m1_ready : m0_ready, n == r);
         chk("lose_ready", w ? m0_ready : m1_ready, 1'b0);
         chk("lose_err", w ? m0_err : m1_err, 1'b0);
         chk("lose_rdata", w ? m0_rdata : m1_rdata, 32'h0);
         if (n == r) begin
            chk("win_err", w ? m1_err : m0_err, !ok);
            chk("win_rdata", w ? m1_rdata : m0_rdata, exp_rd);
         end
      end
      last_g = w;
      s_ready = '0;
      if (!keep) begin
         m0_valid = 1'b0;
         m1_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("idle_grant", grant, 2'b00);
      chk("idle_m0_ready", m0_ready, 1'b0);
      chk("idle_m1_ready", m1_ready, 1'b0);
      chk("idle_s_valid", s_valid, 1'b0);
   endtask

   initial begin
      #2 rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_grant", grant, 2'b00);
      chk("rst_s_valid", s_valid, 1'b0);
      chk("rst_m0_ready", m0_ready, 1'b0);
      chk("rst_m1_ready", m1_ready, 1'b0);
      chk("rst_s_addr", s_addr, 32'h0);
      rst = 1'b0;

      // both requesting continuously: m0, m1, m0, m1
      for (int i = 0; i < 4; i++)
         txn(1, 1, 32'h4000_0010, 32'h4000_1020, 32'h11, 32'h22,
             1, 0, 1, i < 3, 0, 0, 0, 32'h0);

      txn(1, 0, 32'h4000_1008, 32'h0, 32'h1234_5678, 32'h0,
          1, 0, 1, 0, 0, 0, 0, 32'h0);
      txn(0, 1, 32'h0, 32'h4000_3100, 32'h0, 32'h0,
          0, 0, 2, 0, 0, 1, 1, 32'hCAFE_F00D);
      txn(1, 0, 32'h5000_0000, 32'h0, 32'h0, 32'h0,
          0, 0, 1, 0, 0, 1, 0, 32'h0);
      txn(0, 1, 32'h0, 32'h4000_2004, 32'h0, 32'h0,
          0, 0, 0, 0, 0, 1, 0, 32'h0);
      txn(1, 0, 32'h4000_0040, 32'h0, 32'h0, 32'h0,
          0, 0, TO, 0, 0, 1, 0, 32'h0);
      txn(0, 1, 32'h0, 32'h4000_3000, 32'h0, 32'h0,
          0, 0, 3, 0, 1, 1, 0, 32'h0);

      // reset while waiting on a slave
      m1_addr = 32'h4000_2004; m1_we = 1'b0; m1_valid = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_grant", grant, 2'b00);
      chk("mid_rst_s_addr", s_addr, 32'h0);
      chk("mid_rst_m1_ready", m1_ready, 1'b0);
      @(posedge clk); #1;
      chk("rst_hold_m1_ready", m1_ready, 1'b0);
      rst = 1'b0;
      last_g = 1;
      txn(0, 1, 32'h0, 32'h4000_2004, 32'h0, 32'h0,
          0, 0, 2, 0, 0, 0, 0, 32'h0);

      for (int i = 0; i < 40; i++) begin
         int v, sel, dly;
         v = $urandom_range(1, 3);
         sel = $urandom_range(0, 9);
         dly = (sel == 0) ? 0 : ((sel == 1) ? TO : $urandom_range(1, 4));
         txn(v[0], v[1], rand_addr(), rand_addr(), $urandom, $urandom,
             1'($urandom), 1'($urandom), dly, 1'($urandom),
             $urandom_range(0, 3) == 0, 1'($urandom), 0, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
